csr_regfile_m: RTL and testbench

Parametrised machine-mode CSR file for the core: the successor of the single-register (mscratch-only) CSR block. It implements read/write/set/clear CSR ops, trap entry and mret sequencing, interrupt pending/enable logic, and 64-bit cycle/instret counters. It sits beside the execute stage: decode supplies the CSR address and op, and the trap controller supplies trap and mret events.

---
 rtl/csr_pkg.sv | 34 +++
 rtl/csr_counter64.sv | 21 ++
 rtl/csr_regfile_m.sv | 143 ++++++++++++++
 tb/tb_csr_regfile_m.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, op encodings, field indices and cause codes
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {OP_NONE, OP_WRITE, OP_SET, OP_CLEAR} csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIP_MSIP       = 3;
    localparam int MIP_MTIP       = 7;
    localparam int MIP_MEIP       = 11;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    localparam logic [31:0] MISA_RV32I = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK   = (32'd1 << MIP_MSIP) | (32'd1 << MIP_MTIP) | (32'd1 << MIP_MEIP);
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit wrapping counter; a write to either half replaces it and skips that cycle's increment
module csr_counter64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] w_data,
    output logic [63:0] value
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            value <= '0;
        else if (wr_lo)
            value[31:0] <= w_data;
        else if (wr_hi)
            value[63:32] <= w_data;
        else if (inc)
            value <= value + 64'd1;
    end
endmodule

// File: rtl/csr_regfile_m.sv
// csr_regfile_m: machine-mode CSR file with trap/mret sequencing, interrupt gating and 64-bit counters
module csr_regfile_m
    import csr_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET  = '0,
    parameter bit               HAS_COUNTERS = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_w_data,
    input  logic [1:0]      csr_op,
    output logic [XLEN-1:0] csr_r_data,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            instret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] epc,
    output logic            irq_pending
);
    logic            st_mie, st_mpie, impl, ro, is_cnt, we;
    logic [XLEN-1:0] mie_r, mtvec, mscratch, mepc, mcause, mtval;
    logic [XLEN-1:0] mstatus, mip, wdata, base;
    logic [63:0]     cyc, ins;

    always_comb begin
        mstatus = '0;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus[MSTATUS_MIE]  = st_mie;
        mstatus[MSTATUS_MPIE] = st_mpie;
        mip = '0;
        mip[MIP_MSIP] = irq_sw;
        mip[MIP_MTIP] = irq_timer;
        mip[MIP_MEIP] = irq_ext;
    end

    always_comb begin
        impl = 1'b1;
        csr_r_data = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_r_data = mstatus;
            CSR_MISA:      csr_r_data = MISA_RV32I;
            CSR_MIE:       csr_r_data = mie_r;
            CSR_MTVEC:     csr_r_data = mtvec;
            CSR_MSCRATCH:  csr_r_data = mscratch;
            CSR_MEPC:      csr_r_data = mepc;
            CSR_MCAUSE:    csr_r_data = mcause;
            CSR_MTVAL:     csr_r_data = mtval;
            CSR_MIP:       csr_r_data = mip;
            CSR_MCYCLE:    csr_r_data = cyc[31:0];
            CSR_MINSTRET:  csr_r_data = ins[31:0];
            CSR_MCYCLEH:   csr_r_data = cyc[63:32];
            CSR_MINSTRETH: csr_r_data = ins[63:32];
            CSR_MHARTID:   csr_r_data = '0;
            default:       impl = 1'b0;
        endcase
    end

    assign is_cnt = csr_addr == CSR_MCYCLE || csr_addr == CSR_MINSTRET ||
                    csr_addr == CSR_MCYCLEH || csr_addr == CSR_MINSTRETH;
    assign ro = csr_addr[11:10] == 2'b11 || csr_addr == CSR_MISA || csr_addr == CSR_MIP ||
                (!HAS_COUNTERS && is_cnt);
    assign csr_illegal = !impl || (csr_op != OP_NONE && ro);
    assign wdata = csr_op == OP_WRITE ? csr_w_data :
                   csr_op == OP_SET   ? csr_r_data | csr_w_data : csr_r_data & ~csr_w_data;
    // trap and mret both swallow any CSR op issued in the same cycle
    assign we = csr_op != OP_NONE && !csr_illegal && !trap_valid && !mret;

    assign base = {mtvec[XLEN-1:2], 2'b00};
    assign trap_vector = (mtvec[1:0] == 2'b01 && trap_cause[XLEN-1]) ?
                         base + XLEN'({trap_cause[4:0], 2'b00}) : base;
    assign epc = mepc;
    assign irq_pending = st_mie & |(mip & mie_r);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            mie_r    <= '0;
            mtvec    <= MTVEC_RESET;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else if (trap_valid) begin
            mepc    <= trap_pc & ~XLEN'(3);
            mcause  <= trap_cause;
            mtval   <= trap_tval;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    st_mie  <= wdata[MSTATUS_MIE];
                    st_mpie <= wdata[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_r    <= wdata & MIE_MASK;
                // MODE values 2/3 are rejected by keeping the previous MODE
                CSR_MTVEC:    mtvec    <= {wdata[XLEN-1:2], wdata[1] ? mtvec[1:0] : wdata[1:0]};
                CSR_MSCRATCH: mscratch <= wdata;
                CSR_MEPC:     mepc     <= wdata & ~XLEN'(3);
                CSR_MCAUSE:   mcause   <= wdata;
                CSR_MTVAL:    mtval    <= wdata;
                default: ;
            endcase
        end
    end

    if (HAS_COUNTERS) begin : g_cnt
        csr_counter64 u_mcycle (
            .clock  (clock),
            .reset  (reset),
            .inc    (1'b1),
            .wr_lo  (we && csr_addr == CSR_MCYCLE),
            .wr_hi  (we && csr_addr == CSR_MCYCLEH),
            .w_data (wdata),
            .value  (cyc)
        );
        csr_counter64 u_minstret (
            .clock  (clock),
            .reset  (reset),
            .inc    (instret),
            .wr_lo  (we && csr_addr == CSR_MINSTRET),
            .wr_hi  (we && csr_addr == CSR_MINSTRETH),
            .w_data (wdata),
            .value  (ins)
        );
    end else begin : g_nocnt
        assign cyc = '0;
        assign ins = '0;
    end
endmodule

// File: tb/tb_csr_regfile_m.sv
// tb_csr_regfile_m: vector table plus hand sequences for traps, mret, counters and async reset
module tb_csr_regfile_m;
    import csr_pkg::*;
    localparam logic [31:0] MTV = 32'h0000_0200;

    logic        clock = 1'b0, reset = 1'b1;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_w_data = '0, trap_cause = '0, trap_pc = '0, trap_tval = '0;
    logic [1:0]  csr_op = '0;
    logic        trap_valid = 0, mret = 0, instret = 0, irq_ext = 0, irq_timer = 0, irq_sw = 0;
    logic [31:0] csr_r_data, trap_vector, epc;
    logic        csr_illegal, irq_pending;

    always #5 clock = ~clock;

    csr_regfile_m #(.XLEN(32), .MTVEC_RESET(MTV), .HAS_COUNTERS(1'b1)) dut (
        .clock(clock), .reset(reset), .csr_addr(csr_addr), .csr_w_data(csr_w_data),
        .csr_op(csr_op), .csr_r_data(csr_r_data), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret(mret), .instret(instret), .irq_ext(irq_ext),
        .irq_timer(irq_timer), .irq_sw(irq_sw), .trap_vector(trap_vector),
        .epc(epc), .irq_pending(irq_pending)
    );

    int checks = 0, errors = 0;

    typedef struct {string name; logic [31:0] r; logic ill;} exp_t;
    typedef struct {logic [11:0] a; logic [1:0] op; logic [31:0] w; logic [31:0] r; logic ill;} vec_t;
    exp_t sb[$];
    vec_t v[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input string name, input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] w, input logic [31:0] r, input logic ill);
        exp_t e;
        csr_addr = a;
        csr_op = op;
        csr_w_data = w;
        sb.push_back('{name, r, ill});
        @(negedge clock);
        e = sb.pop_front();
        chk({e.name, ".rd"}, csr_r_data, e.r);
        chk({e.name, ".ill"}, {31'b0, csr_illegal}, {31'b0, e.ill});
        @(posedge clock);
        #1;
        csr_op = OP_NONE;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] w);
        csr_addr = a;
        csr_op = OP_WRITE;
        csr_w_data = w;
        @(posedge clock);
        #1;
        csr_op = OP_NONE;
    endtask

    initial begin
        v[0]  = '{12'h300, OP_NONE,  32'h0,        32'h0000_1800, 1'b0};
        v[1]  = '{12'h305, OP_NONE,  32'h0,        MTV,           1'b0};
        v[2]  = '{12'hF14, OP_NONE,  32'h0,        32'h0,         1'b0};
        v[3]  = '{12'h7C0, OP_NONE,  32'h0,        32'h0,         1'b1};
        v[4]  = '{12'h301, OP_NONE,  32'h0,        32'h4000_0100, 1'b0};
        v[5]  = '{12'h340, OP_WRITE, 32'hDEADBEEF, 32'h0,         1'b0};
        v[6]  = '{12'h340, OP_SET,   32'h0000_0010, 32'hDEADBEEF, 1'b0};
        v[7]  = '{12'h340, OP_CLEAR, 32'h0000_000F, 32'hDEADBEFF, 1'b0};
        v[8]  = '{12'h340, OP_NONE,  32'h0,        32'hDEADBEF0, 1'b0};
        v[9]  = '{12'hF14, OP_WRITE, 32'h5,        32'h0,         1'b1};
        v[10] = '{12'h344, OP_WRITE, 32'hFFF,      32'h0,         1'b1};
        v[11] = '{12'h340, OP_NONE,  32'h0,        32'hDEADBEF0, 1'b0};
        v[12] = '{12'h304, OP_WRITE, 32'hFFFFFFFF, 32'h0,         1'b0};
        v[13] = '{12'h304, OP_NONE,  32'h0,        32'h0000_0888, 1'b0};
        v[14] = '{12'h305, OP_WRITE, 32'h0000_1003, MTV,          1'b0};
        v[15] = '{12'h305, OP_NONE,  32'h0,        32'h0000_1000, 1'b0};
        v[16] = '{12'h305, OP_SET,   32'h1,        32'h0000_1000, 1'b0};
        v[17] = '{12'h305, OP_NONE,  32'h0,        32'h0000_1001, 1'b0};
        v[18] = '{12'h341, OP_WRITE, 32'h0000_1237, 32'h0,        1'b0};
        v[19] = '{12'h341, OP_NONE,  32'h0,        32'h0000_1234, 1'b0};
        v[20] = '{12'h300, OP_WRITE, 32'hFFFFFFFF, 32'h0000_1800, 1'b0};
        v[21] = '{12'h300, OP_NONE,  32'h0,        32'h0000_1888, 1'b0};
        v[22] = '{12'h300, OP_CLEAR, 32'h0000_0080, 32'h0000_1888, 1'b0};
        v[23] = '{12'h300, OP_NONE,  32'h0,        32'h0000_1808, 1'b0};
        v[24] = '{12'h304, OP_WRITE, 32'h0000_0080, 32'h0000_0888, 1'b0};
        v[25] = '{12'h304, OP_NONE,  32'h0,        32'h0000_0080, 1'b0};
        v[26] = '{12'hB02, OP_NONE,  32'h0,        32'h0,         1'b0};

        #1;
        chk("rst_epc", epc, 32'h0);
        chk("rst_irq", {31'b0, irq_pending}, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 27; i++)
            apply($sformatf("vec%0d", i), v[i].a, v[i].op, v[i].w, v[i].r, v[i].ill);

        irq_timer = 1'b1;
        #1;
        chk("irq_pending", {31'b0, irq_pending}, 32'h1);
        apply("mip", CSR_MIP, OP_NONE, 0, 32'h0000_0080, 1'b0);
        trap_valid = 1'b1;
        trap_cause = {1'b1, 26'b0, CAUSE_MTI};
        trap_pc = 32'h0000_2003;
        trap_tval = 32'h55;
        #1;
        chk("vec_irq", trap_vector, 32'h0000_101C);
        apply("trap_cyc", CSR_MSTATUS, OP_NONE, 0, 32'h0000_1808, 1'b0);
        trap_valid = 1'b0;
        chk("trap_epc", epc, 32'h0000_2000);
        chk("trap_irq_masked", {31'b0, irq_pending}, 32'h0);
        apply("trap_mstatus", CSR_MSTATUS, OP_NONE, 0, 32'h0000_1880, 1'b0);
        apply("trap_mcause", CSR_MCAUSE, OP_NONE, 0, 32'h8000_0007, 1'b0);
        apply("trap_mtval", CSR_MTVAL, OP_NONE, 0, 32'h55, 1'b0);
        trap_cause = 32'h2;
        #1;
        chk("vec_exc", trap_vector, 32'h0000_1000);

        mret = 1'b1;
        apply("mret_cyc", CSR_MSTATUS, OP_NONE, 0, 32'h0000_1880, 1'b0);
        mret = 1'b0;
        apply("mret_mstatus", CSR_MSTATUS, OP_NONE, 0, 32'h0000_1888, 1'b0);

        trap_valid = 1'b1;
        mret = 1'b1;
        trap_cause = 32'hB;
        trap_pc = 32'h0000_3000;
        trap_tval = 32'h0;
        apply("prio_cyc", CSR_MSCRATCH, OP_WRITE, 32'h1234_5678, 32'hDEADBEF0, 1'b0);
        trap_valid = 1'b0;
        mret = 1'b0;
        apply("prio_mscratch", CSR_MSCRATCH, OP_NONE, 0, 32'hDEADBEF0, 1'b0);
        apply("prio_mstatus", CSR_MSTATUS, OP_NONE, 0, 32'h0000_1880, 1'b0);
        chk("prio_epc", epc, 32'h0000_3000);
        apply("prio_mcause", CSR_MCAUSE, OP_NONE, 0, 32'hB, 1'b0);
        mret = 1'b1;
        apply("mretwr_cyc", CSR_MSCRATCH, OP_WRITE, 32'h1, 32'hDEADBEF0, 1'b0);
        mret = 1'b0;
        apply("mretwr_mscratch", CSR_MSCRATCH, OP_NONE, 0, 32'hDEADBEF0, 1'b0);
        apply("mretwr_mstatus", CSR_MSTATUS, OP_NONE, 0, 32'h0000_1888, 1'b0);

        wr(CSR_MCYCLE, 32'hFFFF_FFFF);
        wr(CSR_MCYCLEH, 32'hFFFF_FFFF);
        apply("mcycleh_full", CSR_MCYCLEH, OP_NONE, 0, 32'hFFFF_FFFF, 1'b0);
        apply("mcycle_wrap", CSR_MCYCLE, OP_NONE, 0, 32'h0, 1'b0);
        apply("mcycleh_wrap", CSR_MCYCLEH, OP_NONE, 0, 32'h0, 1'b0);
        apply("mcycle_run", CSR_MCYCLE, OP_NONE, 0, 32'h2, 1'b0);

        instret = 1'b1;
        wr(CSR_MINSTRET, 32'h100);
        instret = 1'b0;
        apply("minstret_wr", CSR_MINSTRET, OP_NONE, 0, 32'h100, 1'b0);
        instret = 1'b1;
        apply("minstret_inc_cyc", CSR_MINSTRET, OP_NONE, 0, 32'h100, 1'b0);
        instret = 1'b0;
        apply("minstret_inc", CSR_MINSTRET, OP_NONE, 0, 32'h101, 1'b0);
        apply("minstreth", CSR_MINSTRETH, OP_NONE, 0, 32'h0, 1'b0);

        chk("pre_rst_irq", {31'b0, irq_pending}, 32'h1);
        trap_valid = 1'b1;
        trap_cause = 32'h8000_0003;
        trap_pc = 32'h0000_4000;
        csr_addr = CSR_MSCRATCH;
        #2;
        reset = 1'b1;
        #1;
        chk("async_epc", epc, 32'h0);
        chk("async_irq", {31'b0, irq_pending}, 32'h0);
        chk("async_mscratch", csr_r_data, 32'h0);
        @(posedge clock);
        #1;
        trap_valid = 1'b0;
        reset = 1'b0;
        apply("rst_mepc", CSR_MEPC, OP_NONE, 0, 32'h0, 1'b0);
        apply("rst_mcause", CSR_MCAUSE, OP_NONE, 0, 32'h0, 1'b0);
        apply("rst_mstatus", CSR_MSTATUS, OP_NONE, 0, 32'h0000_1800, 1'b0);
        apply("rst_mtvec", CSR_MTVEC, OP_NONE, 0, MTV, 1'b0);
        apply("rst_mie", CSR_MIE, OP_NONE, 0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
